alu_pipe: RTL and testbench
===========================

Name: alu_pipe

Overview:
- Parametrised, pipelined successor to the single-cycle logic ALU. Same two op banks (mode A, mode B), generalised to WIDTH bits.
- Adds valid/ready handshakes with full backpressure, a programmable IRQ match pattern, an error flag for illegal modes, and a saturating IRQ event counter.
- Sits between the command decoder and the result sink. Produces one result per accepted operation.

Parameters:
- WIDTH, 8, operand/result width in bits (>=2).
- IRQ_CNT_W, 4, width of the saturating IRQ event counter.

Ports:
- alu_clk  input  1  clock; all logic on rising edge.
- alu_rst  input  1  synchronous reset, active-high.
- alu_in_valid  input  1  operation offered.
- alu_in_ready  output  1  block can accept an operation this cycle.
- alu_mode  input  2  01 = mode A bank, 10 = mode B bank, 00/11 = illegal (11 see Optional Feature).
- alu_op  input  2  operation select within the bank.
- alu_in_a  input  WIDTH  operand A.
- alu_in_b  input  WIDTH  operand B.
- alu_irq_pattern  input  WIDTH  result value that raises IRQ; sampled with the operation.
- alu_out_valid  output  1  result available.
- alu_out_ready  input  1  sink accepts result.
- alu_out  output  WIDTH  result.
- alu_err  output  1  qualifies alu_out; 1 = illegal mode, result forced 0.
- alu_irq  output  1  sticky interrupt.
- alu_irq_clr  input  1  clears alu_irq and alu_irq_cnt.
- alu_irq_cnt  output  IRQ_CNT_W  saturating count of IRQ events.

Behaviour:
- Reset is synchronous: alu_rst high at a clock edge clears all state.
  - After reset: alu_out=0, alu_err=0, alu_out_valid=0, alu_irq=0, alu_irq_cnt=0, both stages empty. alu_in_ready=1 from the first cycle after reset.
  - Reset mid-operation discards in-flight operations. No result is emitted for them.
- Input transfer occurs when alu_in_valid && alu_in_ready. Output transfer occurs when alu_out_valid && alu_out_ready.
- Pipeline has two stages:
  - S1 registers mode, op, operands and pattern.
  - S2 registers result, err and IRQ match.
- Latency: 2 cycles from input transfer to alu_out_valid. Throughput is 1 op/cycle when alu_out_ready=1.
- Stall rules:
  - S2 holds while alu_out_valid && !alu_out_ready.
  - S1 advances when S2 is empty or S2 transfers in the same cycle.
  - alu_in_ready = !S1_valid || S1 advancing (combinational from S2 state and alu_out_ready). No bubble on a continuous stream.
- While stalled, alu_out and alu_err are held stable. No data is lost or duplicated.
- Mode A (01) ops:
  - 00: a&b
  - 01: ~(a&b)
  - 10: a|b
  - 11: a^b
- Mode B (10) ops:
  - 00: ~(a^b)
  - 01: a&b
  - 10: ~(a|b)
  - 11: a|b
- All results are WIDTH bits; no special-case zeroing.
- Illegal mode: alu_out=0, alu_err=1, never contributes an IRQ event.
- IRQ event: an output transfer with alu_err=0 and result==pattern sampled with that op. The event is counted at transfer, not at S2 entry.
- alu_irq: set by an event, cleared by alu_irq_clr.
  - Clear and event in the same cycle: alu_irq=1, alu_irq_cnt=1 (new event not lost).
- alu_irq_cnt: +1 per event, saturates at 2^IRQ_CNT_W-1, no wrap.
- alu_irq_clr has no effect on data-path state.

Optional Feature:
- Macro ALU_ARITH_EN.
- Defined: mode 11 is the arithmetic bank. Ops:
  - 00: a+b
  - 01: a-b
  - 10: a+1
  - 11: a-1
- Arithmetic results are modulo 2^WIDTH (carry/borrow discarded). alu_err=0 and IRQ matching apply as in other modes.
- Undefined: mode 11 is illegal, exactly like mode 00.

Test Plan:
- Reset, then a mode A XOR stream: a=0x0F, b=0xF0 for 3 back-to-back ops with alu_out_ready=1 -> first alu_out_valid 2 cycles after first transfer, outputs 0xFF on 3 consecutive cycles, alu_in_ready stays 1.
- Backpressure: issue 4 ops, alu_out_ready=0 for 5 cycles -> alu_in_ready drops after 2 accepted ops, alu_out held constant. Release -> all 4 results in order, none dropped or duplicated.
- IRQ: mode B op 11, a=0xF0, b=0x0F, pattern=0xFF -> alu_irq=1 and cnt=1 at output transfer.
  - Next, alu_irq_clr asserted in the same cycle as another matching transfer -> alu_irq=1, cnt=1.
- Saturation: IRQ_CNT_W=4, 20 matching ops, no clear -> cnt stops at 15. alu_irq_clr -> cnt=0, alu_irq=0.
- Illegal mode 00 with pattern=0x00 -> alu_out=0x00, alu_err=1, no IRQ.
  - With ALU_ARITH_EN: mode 11 op 00, a=0xFF, b=0x02 -> alu_out=0x01, alu_err=0.
- Reset asserted while 2 ops are in flight -> alu_out_valid=0 next cycle, neither result ever appears.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage valid/ready logic ALU with sticky IRQ and saturating IRQ event counter.
// Define ALU_ARITH_EN to turn mode 11 into an arithmetic bank (otherwise mode 11 is illegal).
module alu_pipe #(
  parameter int WIDTH     = 8,
  parameter int IRQ_CNT_W = 4
) (
  input  logic                 alu_clk,
  input  logic                 alu_rst,
  input  logic                 alu_in_valid,
  output logic                 alu_in_ready,
  input  logic [1:0]           alu_mode,
  input  logic [1:0]           alu_op,
  input  logic [WIDTH-1:0]     alu_in_a,
  input  logic [WIDTH-1:0]     alu_in_b,
  input  logic [WIDTH-1:0]     alu_irq_pattern,
  output logic                 alu_out_valid,
  input  logic                 alu_out_ready,
  output logic [WIDTH-1:0]     alu_out,
  output logic                 alu_err,
  output logic                 alu_irq,
  input  logic                 alu_irq_clr,
  output logic [IRQ_CNT_W-1:0] alu_irq_cnt
);
  typedef struct packed {
    logic [1:0]       mode;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] pat;
  } req_t;

  localparam logic [IRQ_CNT_W-1:0] CNT_ONE = IRQ_CNT_W'(1);

  req_t             s1_q;
  logic [2:1]       vld_pipe;
  logic             s2_match;
  logic             s2_free, out_xfer, in_xfer, irq_evt;
  logic [WIDTH-1:0] res;
  logic             err;

  assign out_xfer      = vld_pipe[2] & alu_out_ready;
  assign s2_free       = ~vld_pipe[2] | alu_out_ready;
  assign alu_in_ready  = ~vld_pipe[1] | s2_free;
  assign in_xfer       = alu_in_valid & alu_in_ready;
  assign alu_out_valid = vld_pipe[2];
  // Events are counted when the result leaves S2, not when it enters.
  assign irq_evt       = out_xfer & ~alu_err & s2_match;

  always_comb begin
    res = '0;
    err = 1'b0;
    case (s1_q.mode)
      2'b01:
        case (s1_q.op)
          2'b00:   res = s1_q.a & s1_q.b;
          2'b01:   res = ~(s1_q.a & s1_q.b);
          2'b10:   res = s1_q.a | s1_q.b;
          default: res = s1_q.a ^ s1_q.b;
        endcase
      2'b10:
        case (s1_q.op)
          2'b00:   res = ~(s1_q.a ^ s1_q.b);
          2'b01:   res = s1_q.a & s1_q.b;
          2'b10:   res = ~(s1_q.a | s1_q.b);
          default: res = s1_q.a | s1_q.b;
        endcase
`ifdef ALU_ARITH_EN
      2'b11:
        case (s1_q.op)
          2'b00:   res = s1_q.a + s1_q.b;
          2'b01:   res = s1_q.a - s1_q.b;
          2'b10:   res = s1_q.a + WIDTH'(1);
          default: res = s1_q.a - WIDTH'(1);
        endcase
`endif
      default: err = 1'b1;
    endcase
  end

  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      vld_pipe <= '0;
      s1_q     <= '0;
      alu_out  <= '0;
      alu_err  <= 1'b0;
      s2_match <= 1'b0;
    end else begin
      if (in_xfer) begin
        vld_pipe[1] <= 1'b1;
        s1_q.mode   <= alu_mode;
        s1_q.op     <= alu_op;
        s1_q.a      <= alu_in_a;
        s1_q.b      <= alu_in_b;
        s1_q.pat    <= alu_irq_pattern;
      end else if (s2_free) begin
        vld_pipe[1] <= 1'b0;
      end
      // S2 only loads when it is empty or draining; otherwise result and err stay put.
      if (s2_free) begin
        vld_pipe[2] <= vld_pipe[1];
        if (vld_pipe[1]) begin
          alu_out  <= res;
          alu_err  <= err;
          s2_match <= ~err & (res == s1_q.pat);
        end
      end
    end
  end

  always_ff @(posedge alu_clk) begin
    if (alu_rst) begin
      alu_irq     <= 1'b0;
      alu_irq_cnt <= '0;
    end else if (alu_irq_clr) begin
      // A clear coinciding with an event keeps that event.
      alu_irq     <= irq_evt;
      alu_irq_cnt <= irq_evt ? CNT_ONE : '0;
    end else if (irq_evt) begin
      alu_irq <= 1'b1;
      if (alu_irq_cnt != '1) alu_irq_cnt <= alu_irq_cnt + CNT_ONE;
    end
  end
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: vector table, directed corner sequences, random scoreboard run.
module tb_alu_pipe;
  localparam int WIDTH = 8;
  localparam int IRQ_CNT_W = 4;

  logic                 alu_clk = 1'b0;
  logic                 alu_rst;
  logic                 alu_in_valid, alu_in_ready;
  logic [1:0]           alu_mode, alu_op;
  logic [WIDTH-1:0]     alu_in_a, alu_in_b, alu_irq_pattern;
  logic                 alu_out_valid, alu_out_ready;
  logic [WIDTH-1:0]     alu_out;
  logic                 alu_err, alu_irq, alu_irq_clr;
  logic [IRQ_CNT_W-1:0] alu_irq_cnt;

  alu_pipe #(.WIDTH(WIDTH), .IRQ_CNT_W(IRQ_CNT_W)) dut (
    .alu_clk(alu_clk), .alu_rst(alu_rst),
    .alu_in_valid(alu_in_valid), .alu_in_ready(alu_in_ready),
    .alu_mode(alu_mode), .alu_op(alu_op),
    .alu_in_a(alu_in_a), .alu_in_b(alu_in_b), .alu_irq_pattern(alu_irq_pattern),
    .alu_out_valid(alu_out_valid), .alu_out_ready(alu_out_ready),
    .alu_out(alu_out), .alu_err(alu_err),
    .alu_irq(alu_irq), .alu_irq_clr(alu_irq_clr), .alu_irq_cnt(alu_irq_cnt)
  );

  always #5 alu_clk = ~alu_clk;

  int n_pass = 0;
  int n_chk = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
  endtask

  task automatic step();
    @(posedge alu_clk);
    #1;
  endtask

  task automatic drv(input logic v, input logic [1:0] m, input logic [1:0] o,
                     input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] p);
    alu_in_valid = v; alu_mode = m; alu_op = o;
    alu_in_a = a; alu_in_b = b; alu_irq_pattern = p;
  endtask

  // Reference: {err, result} straight from the bank tables.
  function automatic logic [WIDTH:0] ref_alu(input logic [1:0] m, input logic [1:0] o,
                                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    int unsigned modv;
    modv = 1 << WIDTH;
    r = '0;
    if (m == 2'd1) begin
      if (o == 0) r = a & b; else if (o == 1) r = ~(a & b);
      else if (o == 2) r = a | b; else r = a ^ b;
      return {1'b0, r};
    end else if (m == 2'd2) begin
      if (o == 0) r = ~(a ^ b); else if (o == 1) r = a & b;
      else if (o == 2) r = ~(a | b); else r = a | b;
      return {1'b0, r};
    end
`ifdef ALU_ARITH_EN
    else if (m == 2'd3) begin
      int unsigned ia, ib, s;
      ia = a; ib = b;
      if (o == 0) s = (ia + ib) % modv;
      else if (o == 1) s = (ia + modv - ib) % modv;
      else if (o == 2) s = (ia + 1) % modv;
      else s = (ia + modv - 1) % modv;
      r = s[WIDTH-1:0];
      return {1'b0, r};
    end
`endif
    return {1'b1, {WIDTH{1'b0}}};
  endfunction

  typedef struct {
    logic [1:0]       mode, op;
    logic [WIDTH-1:0] a, b, exp;
    logic             err;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] res;
    logic             err;
    logic             match;
  } exp_t;

  initial begin
    vec_t tbl[$];
    exp_t q[$];
    logic [WIDTH-1:0] got[$];
    logic irq_m;
    int cnt_m, sent, seen;

    tbl.push_back('{2'd1, 2'd0, 8'hCA, 8'hA6, 8'h82, 1'b0});
    tbl.push_back('{2'd1, 2'd1, 8'hCA, 8'hA6, 8'h7D, 1'b0});
    tbl.push_back('{2'd1, 2'd2, 8'hCA, 8'hA6, 8'hEE, 1'b0});
    tbl.push_back('{2'd1, 2'd3, 8'hCA, 8'hA6, 8'h6C, 1'b0});
    tbl.push_back('{2'd2, 2'd0, 8'hCA, 8'hA6, 8'h93, 1'b0});
    tbl.push_back('{2'd2, 2'd1, 8'hCA, 8'hA6, 8'h82, 1'b0});
    tbl.push_back('{2'd2, 2'd2, 8'hCA, 8'hA6, 8'h11, 1'b0});
    tbl.push_back('{2'd2, 2'd3, 8'hCA, 8'hA6, 8'hEE, 1'b0});
    tbl.push_back('{2'd1, 2'd1, 8'h00, 8'h00, 8'hFF, 1'b0});
    tbl.push_back('{2'd0, 2'd2, 8'hCA, 8'hA6, 8'h00, 1'b1});
`ifdef ALU_ARITH_EN
    tbl.push_back('{2'd3, 2'd0, 8'hFF, 8'h02, 8'h01, 1'b0});
    tbl.push_back('{2'd3, 2'd1, 8'hCA, 8'hA6, 8'h24, 1'b0});
    tbl.push_back('{2'd3, 2'd2, 8'hCA, 8'hA6, 8'hCB, 1'b0});
    tbl.push_back('{2'd3, 2'd3, 8'h00, 8'hA6, 8'hFF, 1'b0});
`else
    tbl.push_back('{2'd3, 2'd0, 8'hFF, 8'h02, 8'h00, 1'b1});
`endif

    // Reset state
    alu_rst = 1'b1; alu_irq_clr = 1'b0; alu_out_ready = 1'b1;
    drv(0, 0, 0, 0, 0, 0);
    step(); step();
    alu_rst = 1'b0;
    check("rst_valid", alu_out_valid, 0);
    check("rst_out", alu_out, 0);
    check("rst_err", alu_err, 0);
    check("rst_irq", alu_irq, 0);
    check("rst_cnt", alu_irq_cnt, 0);
    check("rst_in_ready", alu_in_ready, 1);

    // Back-to-back XOR stream: latency 2, no bubbles
    for (int i = 0; i < 6; i++) begin
      drv(i < 3, 2'd1, 2'd3, 8'h0F, 8'hF0, 8'h00);
      #1;
      check("xor_in_ready", alu_in_ready, 1);
      step();
      check("xor_valid", alu_out_valid, (i >= 1 && i <= 3));
      if (i >= 1 && i <= 3) check("xor_out", alu_out, 8'hFF);
    end

    // Backpressure: 4 ops, sink stalled for 5 cycles
    sent = 0;
    got.delete();
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      alu_out_ready = (c >= 5);
      drv(sent < 4, 2'd1, 2'd2, WIDTH'(sent + 1), 8'h00, 8'hAA);
      #1;
      if (c < 5) check("bp_in_ready", alu_in_ready, (c < 2));
      if (c >= 2 && c < 5) begin
        check("bp_hold_valid", alu_out_valid, 1);
        check("bp_hold_out", alu_out, 8'h01);
      end
      if (alu_out_valid && alu_out_ready) got.push_back(alu_out);
      if (alu_in_valid && alu_in_ready) sent++;
      step();
    end
    drv(0, 0, 0, 0, 0, 0);
    check("bp_count", got.size(), 4);
    for (int i = 0; i < got.size(); i++) check("bp_order", got[i], i + 1);
    step(); step();
    check("bp_no_dup", alu_out_valid, 0);

    // IRQ raised at output transfer, not at S2 entry
    alu_irq_clr = 1'b1; step(); alu_irq_clr = 1'b0;
    alu_out_ready = 1'b0;
    drv(1, 2'd2, 2'd3, 8'hF0, 8'h0F, 8'hFF); step();
    drv(0, 0, 0, 0, 0, 0); step();
    check("irq_at_s2_entry", alu_irq, 0);
    step();
    check("irq_stalled", alu_irq, 0);
    check("irq_stalled_out", alu_out, 8'hFF);
    alu_out_ready = 1'b1; step();
    check("irq_set", alu_irq, 1);
    check("irq_cnt1", alu_irq_cnt, 1);
    // Clear coinciding with a matching transfer
    drv(1, 2'd2, 2'd3, 8'hF0, 8'h0F, 8'hFF); step();
    drv(0, 0, 0, 0, 0, 0); step();
    alu_irq_clr = 1'b1; step(); alu_irq_clr = 1'b0;
    check("clr_evt_irq", alu_irq, 1);
    check("clr_evt_cnt", alu_irq_cnt, 1);

    // Saturation
    alu_irq_clr = 1'b1; step(); alu_irq_clr = 1'b0;
    check("clr_cnt", alu_irq_cnt, 0);
    for (int i = 0; i < 20; i++) begin
      drv(1, 2'd2, 2'd3, 8'hF0, 8'h0F, 8'hFF);
      step();
    end
    drv(0, 0, 0, 0, 0, 0);
    step(); step(); step();
    check("sat_cnt", alu_irq_cnt, 15);
    check("sat_irq", alu_irq, 1);
    alu_irq_clr = 1'b1; step(); alu_irq_clr = 1'b0;
    check("sat_clr_cnt", alu_irq_cnt, 0);
    check("sat_clr_irq", alu_irq, 0);

    // Illegal mode with zero pattern never raises IRQ
    drv(1, 2'd0, 2'd0, 8'hFF, 8'hFF, 8'h00); step();
    drv(0, 0, 0, 0, 0, 0); step();
    check("ill_valid", alu_out_valid, 1);
    check("ill_out", alu_out, 0);
    check("ill_err", alu_err, 1);
    step();
    check("ill_no_irq", alu_irq, 0);
    check("ill_no_cnt", alu_irq_cnt, 0);

    // Reset with two ops in flight
    alu_out_ready = 1'b0;
    drv(1, 2'd1, 2'd3, 8'h0F, 8'hF0, 8'hFF); step();
    drv(1, 2'd1, 2'd3, 8'h0F, 8'hF0, 8'hFF); step();
    drv(0, 0, 0, 0, 0, 0);
    alu_rst = 1'b1; step(); alu_rst = 1'b0;
    check("rstf_valid", alu_out_valid, 0);
    check("rstf_out", alu_out, 0);
    check("rstf_in_ready", alu_in_ready, 1);
    alu_out_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (alu_out_valid) seen++;
      step();
    end
    check("rstf_never_out", seen, 0);
    check("rstf_no_irq", alu_irq, 0);

    // Vector table
    foreach (tbl[i]) begin
      drv(1, tbl[i].mode, tbl[i].op, tbl[i].a, tbl[i].b, ~tbl[i].exp); step();
      drv(0, 0, 0, 0, 0, 0); step();
      check("tbl_valid", alu_out_valid, 1);
      check($sformatf("tbl%0d_out", i), alu_out, tbl[i].exp);
      check($sformatf("tbl%0d_err", i), alu_err, tbl[i].err);
      step();
    end

    // Random stream against the scoreboard
    alu_rst = 1'b1; step(); alu_rst = 1'b0;
    q.delete(); irq_m = 1'b0; cnt_m = 0;
    for (int c = 0; c < 600; c++) begin
      logic [1:0] m, o;
      logic [WIDTH-1:0] a, b, p;
      logic [WIDTH:0] r;
      logic ev;
      m = 2'($urandom_range(0, 3)); o = 2'($urandom_range(0, 3));
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      r = ref_alu(m, o, a, b);
      p = ($urandom_range(0, 2) != 0) ? r[WIDTH-1:0] : WIDTH'($urandom);
      drv($urandom_range(0, 3) != 0, m, o, a, b, p);
      alu_out_ready = $urandom_range(0, 2) != 0;
      alu_irq_clr = $urandom_range(0, 15) == 0;
      #1;
      check("rnd_in_ready", alu_in_ready, (q.size() < 2) || alu_out_ready);
      if (q.size() == 0) check("rnd_idle_valid", alu_out_valid, 0);
      ev = 1'b0;
      if (alu_out_valid && alu_out_ready) begin
        if (q.size() == 0) check("rnd_unexpected_out", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          check("rnd_out", alu_out, e.res);
          check("rnd_err", alu_err, e.err);
          ev = e.match;
        end
      end
      if (alu_in_valid && alu_in_ready)
        q.push_back('{r[WIDTH-1:0], r[WIDTH], !r[WIDTH] && (r[WIDTH-1:0] == p)});
      step();
      if (alu_irq_clr) begin
        irq_m = ev; cnt_m = ev ? 1 : 0;
      end else if (ev) begin
        irq_m = 1'b1;
        if (cnt_m < (1 << IRQ_CNT_W) - 1) cnt_m++;
      end
      check("rnd_irq", alu_irq, irq_m);
      check("rnd_cnt", alu_irq_cnt, cnt_m);
    end
    drv(0, 0, 0, 0, 0, 0);
    alu_irq_clr = 1'b0; alu_out_ready = 1'b1;
    for (int i = 0; i < 10 && q.size() > 0; i++) begin
      #1;
      if (alu_out_valid) begin
        exp_t e;
        e = q.pop_front();
        check("drain_out", alu_out, e.res);
        check("drain_err", alu_err, e.err);
      end
      step();
    end
    check("drain_empty", q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
